// File: rtl/conv_window_coord_gen_if.sv
// Coordinate beat stream between the convolution window sequencer and the
// padding / memory-read stage that consumes it.
interface conv_window_coord_gen_if #(
    parameter int COORD_WIDTH = 8,
    parameter int ADDR_WIDTH  = 16
);
    logic signed [COORD_WIDTH-1:0] coord_x;
    logic signed [COORD_WIDTH-1:0] coord_y;
    logic                          in_bounds;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic                          coord_valid;
    logic                          coord_ready;
    logic                          last_tap;
    logic                          last;

    modport master (
        output coord_x, coord_y, in_bounds, mem_addr, coord_valid, last_tap, last,
        input  coord_ready
    );

    modport slave (
        input  coord_x, coord_y, in_bounds, mem_addr, coord_valid, last_tap, last,
        output coord_ready
    );
endinterface

// File: rtl/conv_window_coord_gen.sv
// Walks every output pixel of a stride-1 convolution and every kernel tap of it,
// streaming signed tap coordinates, an in-bounds flag and a linear address.
module conv_window_coord_gen #(
    parameter int COORD_WIDTH = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int PAD         = 1,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [COORD_WIDTH-1:0] img_width,
    input  logic [COORD_WIDTH-1:0] img_height,
    output logic                   busy,
    output logic                   done,
    conv_window_coord_gen_if.master beat
);

    localparam int EXT_W = COORD_WIDTH + 1;

    typedef logic signed [EXT_W-1:0] ext_t;
    typedef logic [COORD_WIDTH-1:0]  cnt_t;

    typedef struct packed {
        logic signed [COORD_WIDTH-1:0] x;
        logic signed [COORD_WIDTH-1:0] y;
        logic                          inb;
        logic [ADDR_WIDTH-1:0]         addr;
        logic                          last_tap;
        logic                          last;
    } beat_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam ext_t GROW  = ext_t'(2 * PAD - KERNEL_SIZE + 1);
    localparam ext_t PAD_E = ext_t'(PAD);
    localparam ext_t ONE_E = ext_t'(1);
    localparam cnt_t K_MAX = cnt_t'(KERNEL_SIZE - 1);
    localparam cnt_t CNT_1 = cnt_t'(1);

    function automatic ext_t to_ext(input cnt_t v);
        return $signed({1'b0, v});
    endfunction

    // One tap: signed coordinates, bounds test and address, all in COORD_WIDTH+1 bits.
    function automatic beat_t tap_calc(input cnt_t ox, oy, kx, ky, w, h,
                                       input ext_t ow, oh);
        ext_t                  cx;
        ext_t                  cy;
        logic [ADDR_WIDTH-1:0] ya;
        logic [ADDR_WIDTH-1:0] wa;
        logic [ADDR_WIDTH-1:0] xa;
        beat_t                 b;
        cx         = to_ext(ox) + to_ext(kx) - PAD_E;
        cy         = to_ext(oy) + to_ext(ky) - PAD_E;
        b.x        = cx[COORD_WIDTH-1:0];
        b.y        = cy[COORD_WIDTH-1:0];
        b.inb      = !cx[EXT_W-1] && !cy[EXT_W-1] && (cx < to_ext(w)) && (cy < to_ext(h));
        ya         = ADDR_WIDTH'($unsigned(cy));
        wa         = ADDR_WIDTH'(w);
        xa         = ADDR_WIDTH'($unsigned(cx));
        b.addr     = b.inb ? (ya * wa + xa) : '0;
        b.last_tap = (kx == K_MAX) && (ky == K_MAX);
        b.last     = b.last_tap && (to_ext(ox) == ow - ONE_E) && (to_ext(oy) == oh - ONE_E);
        return b;
    endfunction

    state_t state;
    cnt_t   w_p0;
    cnt_t   h_p0;
    cnt_t   ox_p0;
    cnt_t   oy_p0;
    cnt_t   kx_p0;
    cnt_t   ky_p0;
    beat_t  beat_p1;
    logic   vld_p1;

    cnt_t   w_n;
    cnt_t   h_n;
    cnt_t   ox_n;
    cnt_t   oy_n;
    cnt_t   kx_n;
    cnt_t   ky_n;
    ext_t   ow_n;
    ext_t   oh_n;
    logic   empty_n;
    logic   xfer;
    beat_t  beat_n;

    assign xfer = vld_p1 && beat.coord_ready;

    // Stage p0: loop counters of the presented beat and the counters of the one after it.
    always_comb begin
        w_n  = w_p0;
        h_n  = h_p0;
        ox_n = ox_p0;
        oy_n = oy_p0;
        kx_n = kx_p0;
        ky_n = ky_p0;
        if (state == IDLE) begin
            w_n  = img_width;
            h_n  = img_height;
            ox_n = '0;
            oy_n = '0;
            kx_n = '0;
            ky_n = '0;
        end
        ow_n = to_ext(w_n) + GROW;
        oh_n = to_ext(h_n) + GROW;
        if (state != IDLE) begin
            if (kx_p0 != K_MAX) begin
                kx_n = kx_p0 + CNT_1;
            end else begin
                kx_n = '0;
                if (ky_p0 != K_MAX) begin
                    ky_n = ky_p0 + CNT_1;
                end else begin
                    ky_n = '0;
                    if (to_ext(ox_p0) != ow_n - ONE_E) begin
                        ox_n = ox_p0 + CNT_1;
                    end else begin
                        ox_n = '0;
                        oy_n = oy_p0 + CNT_1;
                    end
                end
            end
        end
        empty_n = ow_n[EXT_W-1] || (ow_n == '0) || oh_n[EXT_W-1] || (oh_n == '0);
        beat_n  = tap_calc(ox_n, oy_n, kx_n, ky_n, w_n, h_n, ow_n, oh_n);
    end

    // Stage p1: registered beat; the next beat is loaded only on a transfer so it holds under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            vld_p1  <= 1'b0;
            beat_p1 <= '0;
            w_p0    <= '0;
            h_p0    <= '0;
            ox_p0   <= '0;
            oy_p0   <= '0;
            kx_p0   <= '0;
            ky_p0   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w_p0  <= w_n;
                        h_p0  <= h_n;
                        ox_p0 <= ox_n;
                        oy_p0 <= oy_n;
                        kx_p0 <= kx_n;
                        ky_p0 <= ky_n;
                        if (empty_n) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= RUN;
                            busy    <= 1'b1;
                            vld_p1  <= 1'b1;
                            beat_p1 <= beat_n;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (beat_p1.last) begin
                            state   <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            vld_p1  <= 1'b0;
                            beat_p1 <= '0;
                        end else begin
                            ox_p0   <= ox_n;
                            oy_p0   <= oy_n;
                            kx_p0   <= kx_n;
                            ky_p0   <= ky_n;
                            beat_p1 <= beat_n;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign beat.coord_x     = beat_p1.x;
    assign beat.coord_y     = beat_p1.y;
    assign beat.in_bounds   = beat_p1.inb;
    assign beat.mem_addr    = beat_p1.addr;
    assign beat.last_tap    = beat_p1.last_tap;
    assign beat.last        = beat_p1.last;
    assign beat.coord_valid = vld_p1;

endmodule

// File: tb/tb_conv_window_coord_gen.sv
// Bench for conv_window_coord_gen: directed test-plan vectors, backpressure, restart and
// reset corner cases, then random frames against a nested-loop reference model.
module tb_conv_window_coord_gen;
    localparam int CW = 8;
    localparam int K  = 3;
    localparam int P  = 1;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] img_width;
    logic [CW-1:0] img_height;
    logic          busy;
    logic          done;

    conv_window_coord_gen_if #(.COORD_WIDTH(CW), .ADDR_WIDTH(AW)) bus ();

    conv_window_coord_gen #(
        .COORD_WIDTH(CW), .KERNEL_SIZE(K), .PAD(P), .ADDR_WIDTH(AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .img_width  (img_width),
        .img_height (img_height),
        .busy       (busy),
        .done       (done),
        .beat       (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int inb; int addr; int lt; int l; } beat_s;
    typedef struct { int w; int h; int idx; int x; int y; int inb; int addr; int lt; int l; int total; } vec_s;

    beat_s exp_q[$];
    beat_s got_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Reference: enumerate the output grid and kernel taps directly.
    function automatic void build(input int w, input int h);
        int ow, oh, x, y, inb, lt;
        exp_q.delete();
        ow = w + 2 * P - K + 1;
        oh = h + 2 * P - K + 1;
        if (ow <= 0 || oh <= 0) return;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++) begin
                        x   = ox + kx - P;
                        y   = oy + ky - P;
                        inb = (x >= 0 && x < w && y >= 0 && y < h) ? 1 : 0;
                        lt  = (kx == K - 1 && ky == K - 1) ? 1 : 0;
                        exp_q.push_back('{x, y, inb, inb ? ((y * w + x) & 16'hFFFF) : 0, lt,
                                          (lt && ox == ow - 1 && oy == oh - 1) ? 1 : 0});
                    end
    endfunction

    task automatic check_beat(input int i);
        check($sformatf("beat%0d_x", i),        bus.coord_x,   exp_q[i].x);
        check($sformatf("beat%0d_y", i),        bus.coord_y,   exp_q[i].y);
        check($sformatf("beat%0d_in_bounds", i), bus.in_bounds, exp_q[i].inb);
        check($sformatf("beat%0d_mem_addr", i), bus.mem_addr,  exp_q[i].addr);
        check($sformatf("beat%0d_last_tap", i), bus.last_tap,  exp_q[i].lt);
        check($sformatf("beat%0d_last", i),     bus.last,      exp_q[i].l);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      busy,            0);
        check({tag, "_done"},      done,            0);
        check({tag, "_valid"},     bus.coord_valid, 0);
        check({tag, "_x"},         bus.coord_x,     0);
        check({tag, "_y"},         bus.coord_y,     0);
        check({tag, "_in_bounds"}, bus.in_bounds,   0);
        check({tag, "_mem_addr"},  bus.mem_addr,    0);
        check({tag, "_last_tap"},  bus.last_tap,    0);
        check({tag, "_last"},      bus.last,        0);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic run_frame(input int w, input int h, input bit rnd,
                             input int stall_at, input int restart_at, input int rst_at);
        int n, idx, cyc, stall_n, done_cyc, done_cnt;
        bit saw_vld, saw_busy, rdy;
        build(w, h);
        n = exp_q.size();
        got_q.delete();
        @(negedge clk);
        img_width       = CW'(w);
        img_height      = CW'(h);
        start           = 1'b1;
        bus.coord_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            done_cyc = 0; done_cnt = 0; saw_vld = 0; saw_busy = 0;
            for (int c = 1; c <= 4; c++) begin
                if (done) begin
                    done_cnt++;
                    if (done_cyc == 0) done_cyc = c;
                end
                saw_vld  |= bus.coord_valid;
                saw_busy |= busy;
                @(negedge clk);
            end
            check("empty_valid", saw_vld, 0);
            check("empty_busy", saw_busy, 0);
            check("empty_done_count", done_cnt, 1);
            vectors++;
            if (done_cyc < 1 || done_cyc > 2) begin
                miscompares++;
                $display("FAIL empty_done_cycle: got %0d, required 1 or 2", done_cyc);
            end
            return;
        end
        idx = 0; cyc = 0; stall_n = 0;
        while (idx < n && cyc < 4 * n + 100) begin
            if (rst_at >= 0 && idx == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("rst_mid");
                @(negedge clk);
                check("rst_no_done", done, 0);
                rst_n = 1'b1;
                @(negedge clk);
                check("rst_after_done", done, 0);
                check("rst_after_busy", busy, 0);
                return;
            end
            rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (idx == stall_at && stall_n < 5) begin
                rdy = 1'b0;
                stall_n++;
            end
            start = (idx == restart_at);
            if (start) begin
                img_width  = CW'($urandom_range(0, 7));
                img_height = CW'($urandom_range(0, 7));
            end
            bus.coord_ready = rdy;
            check("busy_run", busy, 1);
            check("valid_run", bus.coord_valid, 1);
            if (bus.coord_valid) begin
                check_beat(idx);
                if (rdy) begin
                    got_q.push_back('{int'(bus.coord_x), int'(bus.coord_y), int'(bus.in_bounds),
                                      int'(bus.mem_addr), int'(bus.last_tap), int'(bus.last)});
                    idx++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        bus.coord_ready = 1'b1;
        check("beats_transferred", idx, n);
        if (!rnd && stall_at < 0) check("cycles_per_frame", cyc, n);
        if (stall_at >= 0) check("stall_cycles", cyc, n + 5);
        check("done_pulse", done, 1);
        check("valid_after_last", bus.coord_valid, 0);
        check("busy_after_last", busy, 0);
        @(negedge clk);
        check("done_width", done, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_s tbl[5];
        tbl[0] = '{3, 3,  0, -1, -1, 0, 0, 0, 0, 81};
        tbl[1] = '{3, 3,  4,  0,  0, 1, 0, 0, 0, 81};
        tbl[2] = '{3, 3,  8,  1,  1, 1, 4, 1, 0, 81};
        tbl[3] = '{3, 3, 80,  3,  3, 0, 0, 1, 1, 81};
        tbl[4] = '{4, 2, 66,  2,  1, 1, 6, 0, 0, 72};

        rst_n = 1'b0; start = 1'b0; img_width = '0; img_height = '0;
        bus.coord_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].w, tbl[i].h, 1'b0, -1, -1, -1);
            check($sformatf("tbl%0d_total", i), got_q.size(), tbl[i].total);
            if (got_q.size() > tbl[i].idx) begin
                check($sformatf("tbl%0d_x", i),        got_q[tbl[i].idx].x,    tbl[i].x);
                check($sformatf("tbl%0d_y", i),        got_q[tbl[i].idx].y,    tbl[i].y);
                check($sformatf("tbl%0d_in_bounds", i), got_q[tbl[i].idx].inb, tbl[i].inb);
                check($sformatf("tbl%0d_mem_addr", i), got_q[tbl[i].idx].addr, tbl[i].addr);
                check($sformatf("tbl%0d_last_tap", i), got_q[tbl[i].idx].lt,   tbl[i].lt);
                check($sformatf("tbl%0d_last", i),     got_q[tbl[i].idx].l,    tbl[i].l);
            end else begin
                check($sformatf("tbl%0d_beat_present", i), got_q.size(), tbl[i].idx + 1);
            end
        end

        run_frame(3, 3, 1'b0, 10, -1, -1);
        check("stall_total", got_q.size(), 81);

        run_frame(0, 3, 1'b0, -1, -1, -1);

        run_frame(3, 3, 1'b0, -1, 20, -1);
        check("restart_ignored_total", got_q.size(), 81);

        run_frame(3, 3, 1'b0, -1, -1, 40);
        run_frame(3, 3, 1'b0, -1, -1, -1);
        check("post_reset_total", got_q.size(), 81);
        if (got_q.size() > 0) check("post_reset_beat0_x", got_q[0].x, -1);

        for (int r = 0; r < 12; r++)
            run_frame($urandom_range(0, 9), $urandom_range(0, 9), 1'b1, -1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/conv_window_coord_gen.md
Name: conv_window_coord_gen

Overview:
- Sequencer on the read side of the convolution datapath. It walks every output pixel of a stride-1 convolution and, for each one, every kernel tap.
- For each tap it issues the signed input coordinate pair, an in-bounds flag and a linear memory address.
- Out-of-bounds coordinates are issued on purpose. The downstream padding check / memory read stage turns them into zero-padding.
- Streams over a valid/ready handshake, with window-end and frame-end markers.

Parameters:
- COORD_WIDTH, 8, signed coordinate width; image dimensions must be < 2^(COORD_WIDTH-1)-PAD.
- KERNEL_SIZE, 3, square kernel edge length (>=1).
- PAD, 1, zero-padding on each edge (0 <= PAD < KERNEL_SIZE).
- ADDR_WIDTH, 16, linear memory address width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle frame start request; accepted only in IDLE
- img_width  input  COORD_WIDTH  image width W (unsigned); latched on accepted start
- img_height  input  COORD_WIDTH  image height H (unsigned); latched on accepted start
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse at frame completion
- coord_x  output  COORD_WIDTH  signed tap x = ox + kx - PAD
- coord_y  output  COORD_WIDTH  signed tap y = oy + ky - PAD
- in_bounds  output  1  high when 0<=coord_x<W and 0<=coord_y<H
- mem_addr  output  ADDR_WIDTH  coord_y*W + coord_x when in_bounds, else 0
- coord_valid  output  1  beat valid
- coord_ready  input  1  downstream accepts beat
- last_tap  output  1  beat is the final tap (ky=kx=K-1) of its window
- last  output  1  beat is the final beat of the frame

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 (busy, done, coord_valid, last_tap, last, in_bounds, coord_x, coord_y, mem_addr). Reset mid-frame abandons the frame; no done pulse.
- Output grid:
  - OW = W + 2*PAD - K + 1 and OH = H + 2*PAD - K + 1, both computed signed.
  - If OW<=0 or OH<=0 the frame is empty.
- Loop order: oy (outermost), ox, ky, kx (innermost). Each counter wraps to 0 and carries into the next one out.
- FSM:
  - IDLE: on start, latch W and H.
    - Non-empty frame: go to RUN; first beat (ox=oy=ky=kx=0) is presented with coord_valid=1 on the next cycle.
    - Empty frame: go to DONE; no beats issued.
  - RUN:
    - A beat transfers when coord_valid & coord_ready.
    - While coord_valid & !coord_ready, all beat outputs hold stable.
    - On transfer of a non-final beat, the next beat appears the following cycle. There are no bubbles: 1 beat/cycle under constant ready.
    - On transfer of the beat with last=1, drop coord_valid and go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE. start and reset together: reset wins.
- All beat outputs are registered (flopped). Combinational ready-to-valid paths are forbidden.
- Arithmetic: coordinates and the bounds compare are evaluated in signed COORD_WIDTH+1 bits. The address multiply is truncated to ADDR_WIDTH.
- Beat count per frame = OW*OH*K*K.

Test Plan:
- W=H=3, K=3, PAD=1, ready always 1:
  - 81 beats, one per cycle.
  - beat0 = (-1,-1), in_bounds=0, addr=0.
  - beat4 = (0,0), in_bounds=1, addr=0.
  - beat8 has last_tap=1.
  - beat80 = (3,3), in_bounds=0, last=1.
  - done pulses one cycle after beat80.
- W=4, H=2: beat 66 (oy=1, ox=3, ky=1, kx=0) = (2,1), in_bounds=1, mem_addr=6. Total beats = 72.
- Backpressure on the 3x3 frame: hold ready=0 for 5 cycles at beat 10. The beat 10 outputs stay constant; after release the sequence resumes with no beat lost or duplicated; still 81 transfers.
- W=0, H=3, K=3, PAD=1: no coord_valid; done pulses 2 cycles after start; busy never asserts.
- Pulse start again at beat 20 of a frame: it is ignored and the frame completes normally. Then deassert rst_n at beat 40 of a new frame: all outputs go to 0 immediately, no done pulse, and the next start restarts from beat0.
